valid_ready_rr_arbiter: RTL

VALID_READY_RR_ARBITER -- requirements
Module: valid_ready_rr_arbiter

---
 rtl/valid_ready_rr_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/valid_ready_rr_arbiter.sv
// Round-robin, packet-locked arbiter: N valid/ready requesters merged onto one
// stream through a 2-entry skid FIFO that carries {data, last, src}.
module valid_ready_rr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    input  logic [NUM_REQ-1:0]               req_last,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             out_valid,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_last,
    output logic [$clog2(NUM_REQ)-1:0]       out_src,
    input  logic                             out_ready
);

    localparam int unsigned SRC_W = $clog2(NUM_REQ);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
        logic [SRC_W-1:0]      src;
    } entry_t;

    state_t            state;
    state_t            state_nxt;
    logic [SRC_W-1:0]  gnt;
    logic [SRC_W-1:0]  gnt_nxt;
    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  rr_ptr_nxt;

    entry_t            fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;

    logic              push;
    logic              pop;
    logic              fifo_room;
    logic              gnt_valid;
    logic              gnt_last;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic              found;
    logic [SRC_W-1:0]  pick;

    // Select the granted requester's beat
    always_comb begin
        gnt_valid = 1'b0;
        gnt_last  = 1'b0;
        gnt_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt == SRC_W'(i)) begin
                gnt_valid = req_valid[i];
                gnt_last  = req_last[i];
                gnt_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // First valid requester at or after rr_ptr, by circular distance
    always_comb begin
        int unsigned best_d;
        int unsigned d;
        best_d = NUM_REQ;
        pick   = rr_ptr;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            d = (i + NUM_REQ - 32'(rr_ptr)) % NUM_REQ;
            if (req_valid[i] && (d < best_d)) begin
                best_d = d;
                pick   = SRC_W'(i);
            end
        end
        found = (best_d < NUM_REQ);
    end

    assign fifo_room = (count < 2'd2);
    assign push      = (state == LOCK) && fifo_room && gnt_valid;
    assign pop       = (count != 2'd0) && out_ready;

    // FSM state, grant and round-robin pointer registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ARB;
            gnt    <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // Next-state: pick a requester in ARB, release the lock on an accepted last beat
    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        rr_ptr_nxt = rr_ptr;
        case (state)
            ARB: begin
                if (found) begin
                    gnt_nxt   = pick;
                    state_nxt = LOCK;
                end
            end
            LOCK: begin
                if (push && gnt_last) begin
                    state_nxt  = ARB;
                    rr_ptr_nxt = (gnt == SRC_W'(NUM_REQ - 1)) ? '0 : gnt + SRC_W'(1);
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    // Ready decode from registered state only: locked, FIFO not full, granted index
    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state == LOCK) && fifo_room && (gnt == SRC_W'(i));
        end
    end

    // Two-entry skid FIFO; reset discards any buffered beats
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= '{data: gnt_data, last: gnt_last, src: gnt};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Downstream view of the FIFO head
    assign out_valid = (count != 2'd0);
    assign out_data  = fifo_mem[rd_ptr].data;
    assign out_last  = fifo_mem[rd_ptr].last;
    assign out_src   = fifo_mem[rd_ptr].src;

endmodule
